// File: rtl/aes_pkg.sv
// Shared definitions for the AES round pipeline stages.
//   byte_t                     - one state-array byte
//   state_array_t              - full state, indexed [row][column]
//   stage_state_t              - per-stage handshake state, shared with aes_subbytes
//   AES_STATE_ARRAY_DIMENSION  - default rows/columns of the state array
//   AES_POLY_REDUCE            - x^8 reduction term of the AES field polynomial
//   xtime()                    - multiply-by-2 in GF(2^8)
package aes_pkg;

    localparam int unsigned AES_STATE_ARRAY_DIMENSION = 4;
    localparam logic [7:0]  AES_POLY_REDUCE           = 8'h1b;

    typedef logic [7:0] byte_t;

    typedef byte_t [0:AES_STATE_ARRAY_DIMENSION-1][0:AES_STATE_ARRAY_DIMENSION-1] state_array_t;

    typedef enum logic [1:0] {
        STATE_IDLE,
        STATE_RUNNING,
        STATE_DONE
    } stage_state_t;

    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY_REDUCE : 8'h00);
    endfunction

endpackage

// File: rtl/aes_shiftrows_mixcolumns_if.sv
// Handshake and data bundle between aes_subbytes and AddRoundKey.
//   valid, final_round, state_array  - upstream block and its qualifier
//   next_is_ready                    - downstream can accept a result
//   ready                            - stage can accept a block
//   valid_out, state_array_out       - result and its qualifier
// master: the side driving the block (upstream + downstream view)
// slave : the ShiftRows/MixColumns stage
interface aes_shiftrows_mixcolumns_if;
    import aes_pkg::*;

    logic         valid;
    logic         next_is_ready;
    logic         final_round;
    state_array_t state_array;
    state_array_t state_array_out;
    logic         ready;
    logic         valid_out;

    modport master (
        output valid,
        output next_is_ready,
        output final_round,
        output state_array,
        input  state_array_out,
        input  ready,
        input  valid_out
    );

    modport slave (
        input  valid,
        input  next_is_ready,
        input  final_round,
        input  state_array,
        output state_array_out,
        output ready,
        output valid_out
    );

endinterface

// File: rtl/aes_mix_single_column.sv
// Combinational MixColumns on one 4-byte column, with a bypass for the
// final round.
//   column_in  - shifted column s0..s3
//   bypass     - 1: pass column_in through unchanged
//   column_out - mixed (or bypassed) column
module aes_mix_single_column
    import aes_pkg::*;
(
    input  byte_t [0:3] column_in,
    input  logic        bypass,
    output byte_t [0:3] column_out
);

    byte_t s0, s1, s2, s3;
    byte_t d0, d1, d2, d3;  // 2*s
    byte_t t0, t1, t2, t3;  // 3*s

    always_comb begin
        s0 = column_in[0];
        s1 = column_in[1];
        s2 = column_in[2];
        s3 = column_in[3];
        d0 = xtime(s0);
        d1 = xtime(s1);
        d2 = xtime(s2);
        d3 = xtime(s3);
        t0 = d0 ^ s0;
        t1 = d1 ^ s1;
        t2 = d2 ^ s2;
        t3 = d3 ^ s3;

        if (bypass) begin
            column_out = column_in;
        end else begin
            column_out[0] = d0 ^ t1 ^ s2 ^ s3;
            column_out[1] = s0 ^ d1 ^ t2 ^ s3;
            column_out[2] = s0 ^ s1 ^ d2 ^ t3;
            column_out[3] = t0 ^ s1 ^ s2 ^ d3;
        end
    end

endmodule

// File: rtl/aes_shiftrows_mixcolumns.sv
// AES round stage: ShiftRows followed by MixColumns (skipped on the final
// round). Column-serial: one output column per cycle over four cycles.
//   clock, reset - clock and synchronous active-high reset
//   bus (slave)  - valid/ready/next_is_ready handshake, final_round,
//                  state_array in, state_array_out (registered), valid_out
module aes_shiftrows_mixcolumns
    import aes_pkg::*;
#(
    parameter int unsigned STATE_ARRAY_DIMENSION = AES_STATE_ARRAY_DIMENSION
) (
    input logic                        clock,
    input logic                        reset,
    aes_shiftrows_mixcolumns_if.slave  bus
);

    if (STATE_ARRAY_DIMENSION != 4) begin : g_bad_dimension
        $error("aes_shiftrows_mixcolumns: STATE_ARRAY_DIMENSION must be 4");
    end

    stage_state_t state, state_next;
    logic [1:0]   col;
    state_array_t in_reg;
    logic         final_reg;
    state_array_t out_reg;
    byte_t [0:3]  shifted;
    byte_t [0:3]  mixed;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= STATE_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = STATE_IDLE;
        case (state)
            STATE_IDLE:    state_next = bus.valid ? STATE_RUNNING : STATE_IDLE;
            STATE_RUNNING: state_next = (col == 2'd3) ? STATE_DONE : STATE_RUNNING;
            STATE_DONE:    state_next = bus.next_is_ready ? STATE_IDLE : STATE_DONE;
            default:       state_next = STATE_IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        bus.ready     = (state == STATE_IDLE);
        bus.valid_out = (state == STATE_DONE);
    end

    // ShiftRows for the current column: row r is rotated left by r, so the
    // byte landing in column col comes from column col+r (2-bit wrap).
    always_comb begin
        shifted    = '0;
        shifted[0] = in_reg[0][col];
        shifted[1] = in_reg[1][col + 2'd1];
        shifted[2] = in_reg[2][col + 2'd2];
        shifted[3] = in_reg[3][col + 2'd3];
    end

    aes_mix_single_column u_mix (
        .column_in  (shifted),
        .bypass     (final_reg),
        .column_out (mixed)
    );

    // Capture, column counter and result register
    always_ff @(posedge clock) begin
        if (reset) begin
            col       <= '0;
            in_reg    <= '0;
            final_reg <= 1'b0;
            out_reg   <= '0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (bus.valid) begin
                        in_reg    <= bus.state_array;
                        final_reg <= bus.final_round;
                        col       <= '0;
                    end
                end
                STATE_RUNNING: begin
                    out_reg[0][col] <= mixed[0];
                    out_reg[1][col] <= mixed[1];
                    out_reg[2][col] <= mixed[2];
                    out_reg[3][col] <= mixed[3];
                    // Wraps 3 -> 0 on the transition to DONE.
                    col             <= col + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.state_array_out = out_reg;

endmodule

// File: tb/tb_aes_shiftrows_mixcolumns.sv
// Directed self-checking bench for aes_shiftrows_mixcolumns.
module tb_aes_shiftrows_mixcolumns;
    import aes_pkg::*;

    logic clock = 1'b0;
    logic reset;

    aes_shiftrows_mixcolumns_if bus ();

    aes_shiftrows_mixcolumns #(.STATE_ARRAY_DIMENSION(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Vectors, row-major: [0][0] is the most significant byte.
    localparam state_array_t SR_IN   = 128'h00010203_10111213_20212223_30313233;
    localparam state_array_t SR_EXP  = 128'h00010203_11121310_22232021_33303132;
    localparam state_array_t MC1_IN  = 128'hdbdbdbdb_13131313_53535353_45454545;
    localparam state_array_t MC1_EXP = 128'h8e8e8e8e_4d4d4d4d_a1a1a1a1_bcbcbcbc;
    localparam state_array_t MC2_IN  = 128'hf2f2f2f2_0a0a0a0a_22222222_5c5c5c5c;
    localparam state_array_t MC2_EXP = 128'h9f9f9f9f_dcdcdcdc_58585858_9d9d9d9d;
    localparam state_array_t MC3_IN  = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;
    localparam state_array_t MC3_EXP = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;
    localparam state_array_t FIPS_IN  = 128'hd4e0b81e_27bfb441_11985d52_aef1e530;
    localparam state_array_t FIPS_EXP = 128'h04e04828_66cbf806_8119d326_e59a7a4c;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Presents one block for a single cycle; returns after the accepting edge.
    task automatic start_block(input state_array_t blk, input logic fin);
        bus.state_array = blk;
        bus.final_round = fin;
        bus.valid       = 1'b1;
        tick();
        bus.valid = 1'b0;
    endtask

    // Runs one block to DONE (bounded) and returns the result; leaves the
    // stage back in IDLE when next_is_ready is high.
    task automatic run_block(input state_array_t blk, input logic fin,
                             output state_array_t result, output logic seen);
        start_block(blk, fin);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (bus.valid_out === 1'b1) seen = 1'b1;
        end
        result = bus.state_array_out;
        if (seen && bus.next_is_ready) tick();
    endtask

    task automatic test_reset();
        state_array_t zero;
        zero = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++;
        if (bus.ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready got=%b exp=1", bus.ready);
        end
        total++;
        if (bus.valid_out !== 1'b0) begin
            bad++; $display("FAIL reset_valid_out got=%b exp=0", bus.valid_out);
        end
        total++;
        if (bus.state_array_out !== zero) begin
            bad++; $display("FAIL reset_out got=%h exp=%h", bus.state_array_out, zero);
        end

        // Reset during the second RUNNING cycle.
        start_block(FIPS_IN, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (bus.ready !== 1'b1) begin
            bad++; $display("FAIL midrun_reset_ready got=%b exp=1", bus.ready);
        end
        total++;
        if (bus.state_array_out !== zero) begin
            bad++; $display("FAIL midrun_reset_out got=%h exp=%h", bus.state_array_out, zero);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (bus.valid_out !== 1'b0 || bus.ready !== 1'b1) begin
                bad++;
                $display("FAIL midrun_reset_idle cyc=%0d got valid_out=%b ready=%b exp valid_out=0 ready=1",
                         i, bus.valid_out, bus.ready);
            end
        end
    endtask

    task automatic test_shiftrows_only();
        start_block(SR_IN, 1'b1);
        total++;
        if (bus.ready !== 1'b0) begin
            bad++; $display("FAIL sr_ready_running got=%b exp=0", bus.ready);
        end
        // Scramble the input: it must not matter after capture.
        bus.state_array = '1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++;
            if (bus.valid_out !== 1'b0) begin
                bad++; $display("FAIL sr_early_valid_out edge=T+%0d got=%b exp=0", i, bus.valid_out);
            end
        end
        tick();
        total++;
        if (bus.valid_out !== 1'b1) begin
            bad++; $display("FAIL sr_valid_out_latency got=%b exp=1", bus.valid_out);
        end
        total++;
        if (bus.state_array_out !== SR_EXP) begin
            bad++; $display("FAIL sr_result got=%h exp=%h", bus.state_array_out, SR_EXP);
        end
        tick();
        total++;
        if (bus.ready !== 1'b1 || bus.state_array_out !== SR_EXP) begin
            bad++; $display("FAIL sr_idle_hold got ready=%b out=%h exp ready=1 out=%h",
                            bus.ready, bus.state_array_out, SR_EXP);
        end
    endtask

    task automatic test_mixcolumns();
        state_array_t res;
        logic seen;
        state_array_t ins  [3];
        state_array_t exps [3];
        ins[0] = MC1_IN; exps[0] = MC1_EXP;
        ins[1] = MC2_IN; exps[1] = MC2_EXP;
        ins[2] = MC3_IN; exps[2] = MC3_EXP;
        for (int v = 0; v < 3; v++) begin
            run_block(ins[v], 1'b0, res, seen);
            total++;
            if (!seen) begin
                bad++; $display("FAIL mc%0d_timeout got valid_out=0 exp=1", v);
            end
            total++;
            if (res !== exps[v]) begin
                bad++; $display("FAIL mc%0d_result got=%h exp=%h", v, res, exps[v]);
            end
        end
    endtask

    task automatic test_fips_round1();
        state_array_t res;
        logic seen;
        run_block(FIPS_IN, 1'b0, res, seen);
        total++;
        if (!seen) begin
            bad++; $display("FAIL fips_timeout got valid_out=0 exp=1");
        end
        total++;
        if (res !== FIPS_EXP) begin
            bad++; $display("FAIL fips_result got=%h exp=%h", res, FIPS_EXP);
        end
    endtask

    task automatic test_backpressure();
        state_array_t res;
        logic seen;
        bus.next_is_ready = 1'b0;
        run_block(MC2_IN, 1'b0, res, seen);
        total++;
        if (!seen || res !== MC2_EXP) begin
            bad++; $display("FAIL bp_result got seen=%b out=%h exp seen=1 out=%h", seen, res, MC2_EXP);
        end
        for (int i = 0; i < 10; i++) begin
            bus.valid       = i[0];
            bus.final_round = ~i[0];
            bus.state_array = {$urandom, $urandom, $urandom, $urandom};
            tick();
            total++;
            if (bus.valid_out !== 1'b1 || bus.ready !== 1'b0 || bus.state_array_out !== MC2_EXP) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d got valid_out=%b ready=%b out=%h exp valid_out=1 ready=0 out=%h",
                         i, bus.valid_out, bus.ready, bus.state_array_out, MC2_EXP);
            end
        end
        bus.valid         = 1'b0;
        bus.next_is_ready = 1'b1;
        tick();
        total++;
        if (bus.ready !== 1'b1 || bus.valid_out !== 1'b0) begin
            bad++; $display("FAIL bp_release got ready=%b valid_out=%b exp ready=1 valid_out=0",
                            bus.ready, bus.valid_out);
        end
        run_block(SR_IN, 1'b1, res, seen);
        total++;
        if (!seen || res !== SR_EXP) begin
            bad++; $display("FAIL bp_next_block got seen=%b out=%h exp seen=1 out=%h", seen, res, SR_EXP);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_vo;
        bus.next_is_ready = 1'b1;
        bus.final_round   = 1'b0;
        bus.state_array   = MC1_IN;
        bus.valid         = 1'b1;
        tick();                       // first block accepted
        bus.state_array = FIPS_IN;    // second block waits on the bus
        for (int i = 1; i <= 14; i++) begin
            tick();
            exp_vo = (i == 4) || (i == 10);
            total++;
            if (bus.valid_out !== exp_vo) begin
                bad++; $display("FAIL b2b_valid_out edge=T+%0d got=%b exp=%b", i, bus.valid_out, exp_vo);
            end
            if (i == 4) begin
                total++;
                if (bus.state_array_out !== MC1_EXP) begin
                    bad++; $display("FAIL b2b_first got=%h exp=%h", bus.state_array_out, MC1_EXP);
                end
            end
            if (i == 5) begin
                total++;
                if (bus.ready !== 1'b1) begin
                    bad++; $display("FAIL b2b_gap_ready got=%b exp=1", bus.ready);
                end
            end
            if (i == 10) begin
                total++;
                if (bus.state_array_out !== FIPS_EXP) begin
                    bad++; $display("FAIL b2b_second got=%h exp=%h", bus.state_array_out, FIPS_EXP);
                end
                bus.valid = 1'b0;
            end
        end
    endtask

    initial begin
        reset             = 1'b1;
        bus.valid         = 1'b0;
        bus.next_is_ready = 1'b1;
        bus.final_round   = 1'b0;
        bus.state_array   = '0;

        test_reset();
        test_shiftrows_only();
        test_mixcolumns();
        test_fips_round1();
        test_backpressure();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_shiftrows_mixcolumns.md
Name: aes_shiftrows_mixcolumns

Overview:
- Round stage directly downstream of aes_subbytes. Consumes the SubBytes state array and applies ShiftRows, then MixColumns unless the round is final.
- Column-serial: computes one output column per cycle.
- Uses the same valid/ready/next_is_ready handshake as the rest of the AES round pipeline, so it chains to AddRoundKey.

Parameters:
- STATE_ARRAY_DIMENSION, 4, rows/columns of the state array. Any value other than 4 is an elaboration error.

Ports:
- clock  input  1  clock
- reset  input  1  synchronous, active-high reset
- valid  input  1  upstream state_array and final_round are valid
- next_is_ready  input  1  downstream stage can accept a result
- final_round  input  1  1 = ShiftRows only (skip MixColumns); sampled with valid
- state_array  input  8 x [4][4]  input state, indexed [row][column]
- state_array_out  output  8 x [4][4]  result, indexed [row][column], driven from a register
- ready  output  1  high in IDLE only
- valid_out  output  1  high in DONE only

Behaviour:
- States: IDLE, RUNNING, DONE. 2-bit column counter col. Internal input capture register in_reg[4][4] and final_reg.
- Reset (synchronous, takes priority in any state, including mid-RUNNING):
  - state = IDLE, col = 0, in_reg = 0, final_reg = 0, state_array_out = all 8'h00.
  - Outputs after reset: ready = 1, valid_out = 0.
- IDLE:
  - On valid: capture state_array into in_reg and final_round into final_reg, then go to RUNNING with col = 0.
  - Otherwise stay in IDLE.
  - Input is not used after capture; upstream may change it freely.
- RUNNING, for each cycle with column c = col:
  - Shifted column: s[r] = in_reg[r][(c+r) mod 4] for r = 0..3. Index arithmetic is 2-bit and wraps naturally.
  - If final_reg = 1: out[r][c] <= s[r].
  - Otherwise MixColumns over GF(2^8):
    - out0 = 2s0^3s1^s2^s3
    - out1 = s0^2s1^3s2^s3
    - out2 = s0^s1^2s2^3s3
    - out3 = 3s0^s1^s2^2s3
    - 2a = {a[6:0],0} ^ (a[7] ? 8'h1b : 0); 3a = 2a ^ a. All arithmetic is 8-bit.
  - If col == 3: go to DONE, col = 0. Otherwise col++.
- DONE:
  - valid_out = 1; state_array_out is stable.
  - If next_is_ready: go to IDLE. Otherwise hold in DONE indefinitely.
- Latency: valid accepted at edge T; columns written at edges T+1..T+4; valid_out high from the cycle after edge T+4. Throughput is 1 block per 6 cycles when next_is_ready is held high.
- state_array_out:
  - Holds its last value through IDLE.
  - Column c is overwritten only during RUNNING.
  - A partially updated array is visible during RUNNING; consumers must qualify it with valid_out.
- Simultaneous events:
  - valid while not in IDLE is ignored; ready = 0, no capture.
  - DONE with next_is_ready=1 and valid=1: goes to IDLE that edge; valid is accepted at the following edge if still asserted.
- Illegal state encoding: recover to IDLE.

Decomposition:
- Shared package aes_pkg:
  - typedef byte_t (logic [7:0])
  - stage state enum {STATE_IDLE, STATE_RUNNING, STATE_DONE}, shared with aes_subbytes
  - STATE_ARRAY_DIMENSION default constant
  - xtime function
  - constant AES_POLY_REDUCE = 8'h1b
- Sub-module aes_mix_single_column:
  - Purely combinational.
  - Inputs: 4 bytes plus a bypass bit. Output: 4 bytes.
  - Instantiated once and time-multiplexed by col.

Test Plan:
- Reset → ready=1, valid_out=0, all outputs 00. Assert reset in the 2nd RUNNING cycle → next cycle IDLE, ready=1, outputs 00, no valid_out.
- ShiftRows only: final_round=1, in[r][c]=8'h{r,c} → valid_out exactly 5 cycles after acceptance. Required outputs: out[0][*]=00,01,02,03; out[1][0]=11, out[1][3]=10; out[2][1]=23; out[3][0]=33.
- MixColumns vector: final_round=0, rows constant across columns (row0=db, row1=13, row2=53, row3=45) → every column 8e,4d,a1,bc. Repeat with f2,0a,22,5c → 9f,dc,58,9d. Repeat with all c6 → all c6.
- FIPS-197 App. B round 1:
  - Input rows d4 e0 b8 1e / 27 bf b4 41 / 11 98 5d 52 / ae f1 e5 30.
  - Required output rows 04 e0 48 28 / 66 cb f8 06 / 81 19 d3 26 / e5 9a 7a 4c.
- Backpressure: hold next_is_ready=0 for 10 cycles in DONE while toggling valid and input → valid_out stays 1, outputs unchanged, ready=0. Release → IDLE next cycle, then a new block is accepted.
- Back-to-back: valid and next_is_ready held high, two different blocks → valid_out pulses 6 cycles apart, each with the correct result, and the second block is unaffected by the first.
